uart_top: RTL and testbench

Full-duplex 8N1 UART: a baud-rate generator, a transmitter, and a 16x-oversampling receiver in one block. It sits between the system's byte-level logic and the serial pins. The system writes a byte with a one-cycle write strobe and collects received bytes through a ready/clear handshake. `tx` and `rx` are independent, so looping `tx` back to `rx` returns every transmitted byte.

---
 rtl/uart_top.sv | 125 ++++++++++++
 tb/tb_uart_top.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_top.sv
// uart_top: full-duplex 8N1 UART (baud generator, transmitter, 16x-oversampling receiver).
//   clk/rst      : system clock, asynchronous active-low reset
//   wr_en/data_in: one-cycle strobe and byte to transmit
//   rdy_clr      : clears rdy
//   rx/tx        : serial input/output, both idle high
//   rdy/data_out : last correctly framed received byte is valid
//   busy         : transmitter occupied
module uart_top #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  input  logic       rdy_clr,
  input  logic       rx,
  output logic       tx,
  output logic       rdy,
  output logic       busy,
  output logic [7:0] data_out
);
  localparam int TX_DIV = CLK_FREQ / BAUD_RATE;
  localparam int RX_DIV = CLK_FREQ / (16 * BAUD_RATE);
  localparam int TW = $clog2(TX_DIV + 1);
  localparam int RW = $clog2(RX_DIV + 1);
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [1:0] {R_START, R_DATA, R_STOP} rx_state_t;
  logic [TW-1:0] tx_cnt;
  logic [RW-1:0] rx_cnt_div;
  logic          tx_tick, rx_tick;
  tx_state_t     tx_state;
  logic [7:0]    tx_byte;
  logic [3:0]    tx_idx;
  rx_state_t     rx_state;
  logic [3:0]    rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_done;
  assign tx_tick = tx_cnt == TW'(TX_DIV - 1);
  assign rx_tick = rx_cnt_div == RW'(RX_DIV - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_cnt     <= '0;
      rx_cnt_div <= '0;
    end else begin
      tx_cnt     <= tx_tick ? '0 : tx_cnt + 1'b1;
      rx_cnt_div <= rx_tick ? '0 : rx_cnt_div + 1'b1;
    end
  // tx_idx 0..7 selects the data bit driven next; 8 means the stop bit is next.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_state <= T_IDLE;
      tx_byte  <= '0;
      tx_idx   <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else
      case (tx_state)
        T_IDLE: if (wr_en) begin
          tx_byte  <= data_in;
          tx_state <= T_START;
          busy     <= 1'b1;
        end
        T_START: if (tx_tick) begin
          tx       <= 1'b0;
          tx_idx   <= '0;
          tx_state <= T_DATA;
        end
        T_DATA: if (tx_tick) begin
          if (tx_idx == 4'd8) begin
            tx       <= 1'b1;
            tx_state <= T_STOP;
          end else begin
            tx     <= tx_byte[tx_idx[2:0]];
            tx_idx <= tx_idx + 1'b1;
          end
        end
        default: if (tx_tick) begin
          tx_state <= T_IDLE;
          busy     <= 1'b0;
        end
      endcase
  // Start detection lands mid-start-bit after 8 low ticks; from then on every
  // 16 ticks (rx_cnt wrapping at 15) is the middle of the next bit.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_state <= R_START;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else if (rx_tick)
      case (rx_state)
        R_START:
          if (rx) rx_cnt <= '0;
          else if (rx_cnt == 4'd7) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= R_DATA;
          end else rx_cnt <= rx_cnt + 1'b1;
        R_DATA: begin
          rx_cnt <= rx_cnt + 1'b1;
          if (rx_cnt == 4'd15) begin
            rx_shift <= {rx, rx_shift[7:1]};
            rx_idx   <= rx_idx + 1'b1;
            if (rx_idx == 3'd7) rx_state <= R_STOP;
          end
        end
        R_STOP: begin
          rx_cnt <= rx_cnt + 1'b1;
          if (rx_cnt == 4'd15) rx_state <= R_START;
        end
        default: rx_state <= R_START;
      endcase
  assign rx_done = rx_tick && rx_state == R_STOP && rx_cnt == 4'd15 && rx;
  // A good frame beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rdy      <= 1'b0;
      data_out <= '0;
    end else begin
      rdy      <= rx_done ? 1'b1 : rdy_clr ? 1'b0 : rdy;
      data_out <= rx_done ? rx_shift : data_out;
    end
endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: randomized loopback and direct-drive checks of uart_top against a frame-level model.
module tb_uart_top;
  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 10_000;
  localparam int BIT       = CLK_FREQ / BAUD_RATE;
  localparam int RX_DIV    = CLK_FREQ / (16 * BAUD_RATE);
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       rdy_clr = 1'b0;
  logic       loop = 1'b1;
  logic       rx_drv = 1'b1;
  logic       rx_line;
  logic       tx, rdy, busy;
  logic [7:0] data_out;
  logic [7:0] exp_data = '0;
  int         checks = 0;
  int         errors = 0;
  assign rx_line = loop ? tx : rx_drv;
  always #5 clk = ~clk;
  uart_top #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rdy_clr(rdy_clr),
    .rx(rx_line), .tx(tx), .rdy(rdy), .busy(busy), .data_out(data_out)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clear_rdy();
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr = 1'b0;
    check("rdy_clr", rdy, 0);
    check("hold_data", data_out, exp_data);
  endtask
  task automatic send_byte(input logic [7:0] b, input bit inject);
    logic [9:0] frame;
    int n;
    bit low_seen;
    frame = {1'b1, b, 1'b0};
    clear_rdy();
    wr_en = 1'b1;
    data_in = b;
    @(negedge clk);
    wr_en = 1'b0;
    data_in = '0;
    check("busy_rise", busy, 1);
    n = 0;
    while (tx && n < BIT + 4) begin @(negedge clk); n++; end
    check("start_seen", tx, 0);
    cycles(BIT / 2);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tx_bit%0d", i), tx, frame[i]);
      if (i == 9) break;
      if (inject && i == 2) begin
        wr_en = 1'b1;
        data_in = 8'h12;
        @(negedge clk);
        wr_en = 1'b0;
        data_in = '0;
        cycles(BIT - 1);
      end else cycles(BIT);
    end
    n = 0;
    while (!rdy && n < BIT) begin @(negedge clk); n++; end
    check("rdy_set", rdy, 1);
    check("rx_data", data_out, b);
    exp_data = b;
    check("busy_mid_stop", busy, 1);
    n = 0;
    while (busy && n < BIT) begin @(negedge clk); n++; end
    check("busy_fall", busy, 0);
    check("rdy_at_busy_fall", rdy, 1);
    if (inject) begin
      low_seen = 1'b0;
      for (int i = 0; i < 2 * BIT; i++) begin
        @(negedge clk);
        if (!tx || busy) low_seen = 1'b1;
      end
      check("no_extra_frame", low_seen, 0);
      check("data_after_inject", data_out, b);
    end
  endtask
  task automatic drive_frame(input logic [7:0] b, input bit good_stop);
    rx_drv = 1'b0;
    cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      cycles(BIT);
    end
    // A bad stop bit stays low just past its middle so the trailing low time
    // cannot look like a fresh start bit.
    if (good_stop) begin
      rx_drv = 1'b1;
      cycles(BIT);
    end else begin
      rx_drv = 1'b0;
      cycles(BIT / 2 + 2 * RX_DIV);
      rx_drv = 1'b1;
      cycles(BIT / 2 - 2 * RX_DIV);
    end
    cycles(BIT);
  endtask
  initial begin
    logic [7:0] r;
    cycles(2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_rdy", rdy, 0);
    check("rst_data", data_out, 8'h00);
    send_byte(8'hAB, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h3C, 1'b1);
    for (int k = 0; k < 6; k++) begin
      r = 8'($urandom);
      send_byte(r, k[0]);
    end
    loop = 1'b0;
    rx_drv = 1'b1;
    cycles(BIT);
    clear_rdy();
    rx_drv = 1'b0;
    cycles(3 * RX_DIV);
    rx_drv = 1'b1;
    cycles(2 * BIT);
    check("glitch_rdy", rdy, 0);
    check("glitch_data", data_out, exp_data);
    drive_frame(8'hA5, 1'b0);
    check("frame_err_rdy", rdy, 0);
    check("frame_err_data", data_out, exp_data);
    drive_frame(8'h5A, 1'b1);
    check("after_err_rdy", rdy, 1);
    check("after_err_data", data_out, 8'h5A);
    exp_data = 8'h5A;
    loop = 1'b1;
    clear_rdy();
    wr_en = 1'b1;
    data_in = 8'hA7;
    @(negedge clk);
    wr_en = 1'b0;
    cycles(3 * BIT);
    #3 rst = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_rdy", rdy, 0);
    check("abort_data", data_out, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    cycles(2 * BIT);
    check("post_abort_rdy", rdy, 0);
    check("post_abort_tx", tx, 1);
    check("post_abort_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
